// File: rtl/seg_capture_if.sv
// seg_capture_if: segment bus, digit enables and decoded readback for seg_capture_decoder
interface seg_capture_if #(
    parameter int NDIG = 4
);
    logic [6:0]        a_seg;
    logic [NDIG-1:0]   an;
    logic              clr;
    logic [4*NDIG-1:0] cif_hexa;
    logic [NDIG-1:0]   dig_valid;
    logic              upd;
    logic [2:0]        upd_idx;
    logic              bad_pat;
    logic              bad_an;
    modport master (output a_seg, an, clr, input cif_hexa, dig_valid, upd, upd_idx, bad_pat, bad_an);
    modport slave (input a_seg, an, clr, output cif_hexa, dig_valid, upd, upd_idx, bad_pat, bad_an);
endinterface

// File: rtl/seg_capture_decoder.sv
// seg_capture_decoder: settle-filtered readback of a multiplexed active-low 7-segment display
// Define SEG_CAPTURE_BLANK_EN to accept the all-off pattern as a blank digit.
module seg_capture_decoder #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4
) (
    input logic          clk,
    input logic          rst,
    seg_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
    localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);
    state_t          state, state_n;
    logic [6:0]      s_seg, r_seg;
    logic [NDIG-1:0] s_an, r_an;
    logic [7:0]      cnt;
    logic [3:0]      dec_val;
    logic [2:0]      idx;
    logic            same, off, ld, one_hot, multi, dec_ok, blank, w_dig, w_pat, w_an;
    assign same    = {s_seg, s_an} == {r_seg, r_an};
    assign off     = &s_an;
    assign one_hot = $countones(~r_an) == 1;
    assign multi   = $countones(~r_an) > 1;
    assign ld      = (state == IDLE) ? !off : (state == SETTLE) ? !same : (state == HOLD) ? (!same && !off) : 1'b0;
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        blank   = 1'b0;
        case (r_seg)
            7'b1000000: dec_val = 4'h0;
            7'b1111001: dec_val = 4'h1;
            7'b0100100: dec_val = 4'h2;
            7'b0110000: dec_val = 4'h3;
            7'b0011001: dec_val = 4'h4;
            7'b0010010: dec_val = 4'h5;
            7'b0000010: dec_val = 4'h6;
            7'b1111000: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0010000: dec_val = 4'h9;
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
`ifdef SEG_CAPTURE_BLANK_EN
            7'b1111111: blank = 1'b1;
`endif
            default:    dec_ok = 1'b0;
        endcase
    end
    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++) if (!r_an[i]) idx = 3'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg <= '1;
            s_an  <= '1;
        end else begin
            s_seg <= bus.a_seg;
            s_an  <= bus.an;
        end
    end
    always_ff @(posedge clk) state <= (rst || bus.clr) ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = off ? IDLE : SETTLE;
            SETTLE:  state_n = (same && cnt >= LAST) ? CAPTURE : SETTLE;
            CAPTURE: state_n = HOLD;
            HOLD:    state_n = same ? HOLD : off ? IDLE : SETTLE;
            default: state_n = IDLE;
        endcase
    end
    // an enable pattern with several digits lit wins over any pattern error
    always_comb begin
        w_an  = state == CAPTURE && multi;
        w_dig = state == CAPTURE && one_hot && dec_ok;
        w_pat = state == CAPTURE && one_hot && !dec_ok;
    end
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_seg         <= '1;
            r_an          <= '1;
            cnt           <= '0;
            bus.cif_hexa  <= '0;
            bus.dig_valid <= '0;
            bus.upd       <= 1'b0;
            bus.upd_idx   <= '0;
            bus.bad_pat   <= 1'b0;
            bus.bad_an    <= 1'b0;
        end else begin
            if (ld) begin
                r_seg <= s_seg;
                r_an  <= s_an;
            end
            cnt         <= ld ? 8'd1 : (state == SETTLE && cnt != 8'hff) ? cnt + 8'd1 : cnt;
            bus.upd     <= w_dig;
            bus.upd_idx <= w_dig ? idx : 3'd0;
            bus.bad_pat <= bus.bad_pat | w_pat;
            bus.bad_an  <= bus.bad_an | w_an;
            for (int i = 0; i < NDIG; i++) begin
                if (w_dig && !r_an[i]) begin
                    bus.cif_hexa[4*i +: 4] <= dec_val;
                    bus.dig_valid[i]       <= !blank;
                end
            end
        end
    end
endmodule
